// File: rtl/seq_stream_gen_pkg.sv
// Shared constants, state encoding and helpers for the serial frame generator.
// Defaults describe the 4-bit 1011 preamble expected by the sequence detectors.
package seq_stream_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_PRE  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_PAR  = 3'd3;
    localparam state_t ST_GAP  = 3'd4;

    localparam int unsigned DEF_DATA_W   = 12;
    localparam int unsigned DEF_PRE_W    = 4;
    localparam int unsigned DEF_GAP_CYC  = 2;
    localparam logic [3:0]  DEF_PREAMBLE = 4'b1011;

    function automatic int unsigned max3(input int unsigned x, input int unsigned y,
                                         input int unsigned z);
        int unsigned m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/seq_stream_gen_if.sv
// Word-in / bit-out bundle between a payload source and the frame generator.
interface seq_stream_gen_if #(
    parameter int unsigned DATA_W = 12
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              a;
    logic              busy;
    logic              frame_done;

    modport master (
        output din, din_valid,
        input  din_ready, a, busy, frame_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, a, busy, frame_done
    );
endinterface

// File: rtl/seq_stream_gen_shreg.sv
// Loadable left-shift payload register; parity is captured once at load time
// so later shifting never disturbs the transmitted parity bit.
module seq_stream_shreg
    import seq_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 12
) (
    input  logic              clck,
    input  logic              ares,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_val,
    output logic              msb,
    output logic              parity
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              parity_q, parity_d;

    // next shift-register contents and latched parity
    always_comb begin
        shreg_d  = shreg_q;
        parity_d = parity_q;
        if (load) begin
            shreg_d  = load_val;
            parity_d = even_parity(32'(load_val));
        end else if (shift) begin
            shreg_d  = shreg_q << 1;
        end else begin
            shreg_d  = shreg_q;
        end
    end

    // payload register with synchronous active-low reset
    always_ff @(posedge clck) begin
        if (!ares) begin
            shreg_q  <= {DATA_W{1'b0}};
            parity_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
        end
    end

    assign msb    = shreg_q[DATA_W-1];
    assign parity = parity_q;

endmodule

// File: rtl/seq_stream_gen.sv
// Serial frame generator: preamble, payload MSB-first, optional even parity, idle gap.
// Outputs are registered from the next state, so state_q always names the bit on 'a'.
module seq_stream_gen
    import seq_stream_pkg::*;
#(
    parameter int unsigned         DATA_W    = DEF_DATA_W,
    parameter int unsigned         PRE_W     = DEF_PRE_W,
    parameter logic [PRE_W-1:0]    PREAMBLE  = DEF_PREAMBLE,
    parameter bit                  PARITY_EN = 1'b1,
    parameter int unsigned         GAP_CYC   = DEF_GAP_CYC
) (
    input  logic             clck,
    input  logic             ares,
    seq_stream_gen_if.slave  bus
);

    localparam int unsigned CNT_MAX   = max3(PRE_W, DATA_W, GAP_CYC);
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned PRE_EXT_W = 1 << CNT_W;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic                 accept_s;
    logic                 load_s;
    logic                 shift_s;
    logic                 msb_s;
    logic                 par_s;
    logic [PRE_EXT_W-1:0] pre_ext_s;

    // Padding the preamble to the counter's full range keeps the bit select exact.
    assign pre_ext_s     = PRE_EXT_W'(PREAMBLE);
    assign bus.din_ready = (state_q == ST_IDLE) && ares;
    assign accept_s      = bus.din_valid && bus.din_ready;

    seq_stream_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clck     (clck),
        .ares     (ares),
        .load     (load_s),
        .shift    (shift_s),
        .load_val (bus.din),
        .msb      (msb_s),
        .parity   (par_s)
    );

    // frame sequencing and shared down-counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_PRE;
                    cnt_d   = PRE_LAST;
                    load_s  = 1'b1;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_DATA;
                    cnt_d   = DAT_LAST;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d   = cnt_q - CNT_ONE;
                end else if (PARITY_EN) begin
                    state_d = ST_PAR;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LAST;
                end
            end
            ST_PAR: begin
                state_d = ST_GAP;
                cnt_d   = GAP_LAST;
            end
            ST_GAP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // registered outputs derived from the state being entered
    always_comb begin
        shift_s = (state_d == ST_DATA);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_GAP) && (state_q != ST_GAP);
        case (state_d)
            ST_PRE:  a_d = pre_ext_s[cnt_d];
            ST_DATA: a_d = msb_s;
            ST_PAR:  a_d = par_s;
            default: a_d = 1'b0;
        endcase
    end

    // state, counter and output flops with synchronous active-low reset
    always_ff @(posedge clck) begin
        if (!ares) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.a          = a_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule
